// File: rtl/jpeg_stream_arb_if.sv
// Stream bundle between N upstream JPEG byte sources, the frame arbiter and the decoder input.
// Signal suffixes are from the arbiter's point of view; "master" is the arbiter side.
interface jpeg_stream_arb_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]    inport_valid_i;
    logic [32*CHANNELS-1:0] inport_data_i;
    logic [4*CHANNELS-1:0]  inport_strb_i;
    logic [CHANNELS-1:0]    inport_last_i;
    logic [CHANNELS-1:0]    inport_accept_o;

    logic                   core_valid_o;
    logic [31:0]            core_data_o;
    logic [3:0]             core_strb_o;
    logic                   core_last_o;
    logic                   core_accept_i;
    logic                   core_idle_i;

    modport master (
        input  inport_valid_i, inport_data_i, inport_strb_i, inport_last_i,
        input  core_accept_i, core_idle_i,
        output inport_accept_o,
        output core_valid_o, core_data_o, core_strb_o, core_last_o
    );

    modport slave (
        output inport_valid_i, inport_data_i, inport_strb_i, inport_last_i,
        output core_accept_i, core_idle_i,
        input  inport_accept_o,
        input  core_valid_o, core_data_o, core_strb_o, core_last_o
    );
endinterface

// File: rtl/jpeg_stream_arb.sv
// Frame-granular N-channel arbiter in front of jpeg_core: one channel owns the decoder from
// its first beat until the decoder has drained, so output pixels map to grant_ch_o.
module jpeg_stream_arb #(
    parameter int CHANNELS  = 4,
    parameter int CH_W      = 2,
    parameter int ARB_MODE  = 0,
    parameter int DRAIN_MIN = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    jpeg_stream_arb_if.master bus,
    output logic            grant_valid_o,
    output logic [CH_W-1:0] grant_ch_o,
    output logic            frame_done_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    localparam logic [7:0] DRAIN_END = 8'(DRAIN_MIN);

    logic [1:0]      state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] last_q, last_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [CHANNELS-1:0] accept_c;
    logic                valid_c;
    logic [31:0]         data_c;
    logic [3:0]          strb_c;
    logic                last_c;

    logic                any_req;
    logic                last_xfer;
    logic                drain_done;
    logic [CH_W-1:0]     winner;

    // Round-robin searches upward from the channel after the previous grant; fixed priority from 0.
    function automatic logic [CH_W-1:0] pick_winner(
        input logic [CHANNELS-1:0] req,
        input logic [CH_W-1:0]     prev
    );
        logic [CH_W-1:0] win;
        logic [CH_W-1:0] idx;
        logic            found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ARB_MODE == 1) begin
                idx = CH_W'(i);
            end else begin
                idx = CH_W'((int'(prev) + 1 + i) % CHANNELS);
            end
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign any_req    = |bus.inport_valid_i;
    assign winner     = pick_winner(bus.inport_valid_i, last_q);
    assign last_xfer  = (state_q == ST_STREAM) && valid_c && bus.core_accept_i && last_c;
    assign drain_done = (state_q == ST_DRAIN) && (cnt_q == DRAIN_END) && bus.core_idle_i;

    // Zero-latency mux: only the granted channel reaches the decoder, and only while streaming.
    always_comb begin
        accept_c = '0;
        valid_c  = 1'b0;
        data_c   = '0;
        strb_c   = '0;
        last_c   = 1'b0;
        if (state_q == ST_STREAM) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (grant_q == CH_W'(c)) begin
                    valid_c     = bus.inport_valid_i[c];
                    data_c      = bus.inport_data_i[32*c +: 32];
                    strb_c      = bus.inport_strb_i[4*c +: 4];
                    last_c      = bus.inport_last_i[c];
                    accept_c[c] = bus.core_accept_i;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    last_d  = winner;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_xfer) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q != DRAIN_END) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // Arbitrating in the done cycle lets the next frame start the cycle after frame_done_o.
                if (drain_done) begin
                    if (any_req) begin
                        grant_d = winner;
                        last_d  = winner;
                        state_d = ST_STREAM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= CH_W'(CHANNELS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.inport_accept_o = accept_c;
    assign bus.core_valid_o    = valid_c;
    assign bus.core_data_o     = data_c;
    assign bus.core_strb_o     = strb_c;
    assign bus.core_last_o     = last_c;

    assign grant_valid_o = (state_q != ST_IDLE);
    assign grant_ch_o    = grant_q;
    assign frame_done_o  = drain_done;

endmodule

// File: tb/tb_jpeg_stream_arb.sv
// Directed bench for jpeg_stream_arb: round-robin instance (dut0) and fixed-priority instance (dut1).
module tb_jpeg_stream_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       gv0, gv1, fd0, fd1;
    logic [1:0] gc0, gc1;

    jpeg_stream_arb_if #(.CHANNELS(4)) b0 ();
    jpeg_stream_arb_if #(.CHANNELS(4)) b1 ();

    jpeg_stream_arb #(.CHANNELS(4), .CH_W(2), .ARB_MODE(0), .DRAIN_MIN(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(b0.master),
        .grant_valid_o(gv0), .grant_ch_o(gc0), .frame_done_o(fd0)
    );

    jpeg_stream_arb #(.CHANNELS(4), .CH_W(2), .ARB_MODE(1), .DRAIN_MIN(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(b1.master),
        .grant_valid_o(gv1), .grant_ch_o(gc1), .frame_done_o(fd1)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] log_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        if (b0.core_valid_o && b0.core_accept_i) log_q.push_back(b0.core_data_o);
    endtask

    task automatic set_ch(input int c, input logic v, input logic [31:0] d, input logic l);
        b0.inport_valid_i[c]         = v;
        b0.inport_data_i[32*c +: 32] = d;
        b0.inport_strb_i[4*c +: 4]   = d[3:0] ^ 4'hA;
        b0.inport_last_i[c]          = l;
    endtask

    task automatic clear_in();
        b0.inport_valid_i = '0; b0.inport_data_i = '0; b0.inport_strb_i = '0; b0.inport_last_i = '0;
        b0.core_accept_i  = 1'b0; b0.core_idle_i = 1'b1;
        b1.inport_valid_i = '0; b1.inport_data_i = '0; b1.inport_strb_i = '0; b1.inport_last_i = '0;
        b1.core_accept_i  = 1'b0; b1.core_idle_i = 1'b1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_sig(input string tag, input int sel);
        logic hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            case (sel)
                0:       hit = b0.core_valid_o;
                1:       hit = fd0;
                default: hit = fd1;
            endcase
            if (hit) break;
            @(negedge clk);
        end
        chk(tag, hit, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   exp_rr[5];
        logic acc3, bad;
        logic [2:0] acc_hi;
        int   nd, nb;

        rst = 1'b1;
        clear_in();

        // reset state and a 3-beat ch2 frame
        do_reset();
        @(negedge clk);
        chk("rst_gv", gv0, 0);        chk("rst_gc", gc0, 0);      chk("rst_fd", fd0, 0);
        chk("rst_cvalid", b0.core_valid_o, 0); chk("rst_cdata", b0.core_data_o, 0);
        chk("rst_cstrb", b0.core_strb_o, 0);   chk("rst_clast", b0.core_last_o, 0);
        chk("rst_acc", b0.inport_accept_o, 0);
        step(); set_ch(2, 1, 32'hA0A0_0001, 0); b0.core_accept_i = 1'b1;
        sample();
        chk("t1_idle_gv", gv0, 0); chk("t1_idle_data", b0.core_data_o, 0); chk("t1_idle_acc", b0.inport_accept_o, 0);
        step(); sample();
        chk("t1_gv", gv0, 1); chk("t1_gc", gc0, 2); chk("t1_cvalid", b0.core_valid_o, 1);
        chk("t1_d0", b0.core_data_o, 32'hA0A0_0001); chk("t1_strb", b0.core_strb_o, 4'hB);
        chk("t1_acc", b0.inport_accept_o, 4'b0100);
        step(); set_ch(2, 1, 32'hA0A0_0002, 0); sample();
        chk("t1_d1", b0.core_data_o, 32'hA0A0_0002);
        step(); set_ch(2, 1, 32'hA0A0_0003, 1); sample();
        chk("t1_d2", b0.core_data_o, 32'hA0A0_0003); chk("t1_last", b0.core_last_o, 1);
        step(); set_ch(2, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) step();
            sample();
            if (k == 1) begin
                chk("t1_drain_cvalid", b0.core_valid_o, 0);
                chk("t1_drain_acc", b0.inport_accept_o, 0);
            end
            chk("t1_done", fd0, (k == 5));
        end
        chk("t1_done_gc", gc0, 2);
        step(); sample();
        chk("t1_post_gv", gv0, 0); chk("t1_post_fd", fd0, 0);

        // round-robin, all channels requesting single-beat frames
        do_reset();
        for (int c = 0; c < 4; c++) set_ch(c, 1, 32'hC0DE_0000 + c, 1);
        b0.core_accept_i = 1'b1;
        exp_rr = '{0, 1, 2, 3, 0};
        @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            wait_sig("t2_start", 0);
            chk("t2_gc", gc0, exp_rr[f]);
            chk("t2_data", b0.core_data_o, 32'hC0DE_0000 + exp_rr[f]);
            @(negedge clk);
            wait_sig("t2_done", 1);
            chk("t2_done_gc", gc0, exp_rr[f]);
            @(negedge clk);
            chk("t2_pulse", fd0, 0);
            chk("t2_regrant", gv0, 1);
        end

        // fixed priority on dut1: ch0 wins every frame
        do_reset();
        for (int c = 0; c < 4; c++) begin
            b1.inport_valid_i[c]         = 1'b1;
            b1.inport_data_i[32*c +: 32] = 32'hF1F0_0000 + c;
            b1.inport_strb_i[4*c +: 4]   = 4'hF;
            b1.inport_last_i[c]          = 1'b1;
        end
        b1.core_accept_i = 1'b1;
        acc_hi = '0; nd = 0; nb = 0;
        @(negedge clk);
        for (int i = 0; i < 60 && nd < 3; i++) begin
            acc_hi |= b1.inport_accept_o[3:1];
            if (b1.inport_accept_o[0] && b1.inport_valid_i[0]) nb++;
            if (fd1) begin
                nd++;
                chk("t3_gc", gc1, 0);
            end
            @(negedge clk);
        end
        chk("t3_frames", nd, 3); chk("t3_beats", nb, 3); chk("t3_acc_hi", acc_hi, 0);

        // backpressure, valid bubble, competing ch3 request
        do_reset();
        log_q.delete();
        set_ch(1, 1, 32'hB000_0000, 0); b0.core_accept_i = 1'b1;
        sample();
        step(); sample();
        chk("t4_gc", gc0, 1); chk("t4_cvalid", b0.core_valid_o, 1);
        step(); set_ch(1, 1, 32'hB000_0001, 0); b0.core_accept_i = 1'b0; set_ch(3, 1, 32'h3333_3333, 1);
        sample();
        chk("t4_stall_acc", b0.inport_accept_o, 4'b0000);
        step(); b0.core_accept_i = 1'b1; sample();
        chk("t4_acc", b0.inport_accept_o, 4'b0010);
        step(); set_ch(1, 0, 32'hB000_0002, 0); sample();
        chk("t4_bubble_cvalid", b0.core_valid_o, 0); chk("t4_bubble_gc", gc0, 1);
        step(); set_ch(1, 1, 32'hB000_0002, 1); b0.core_accept_i = 1'b0; sample();
        step(); b0.core_accept_i = 1'b1; sample();
        step(); set_ch(1, 0, 0, 0);
        acc3 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) step();
            sample();
            acc3 |= b0.inport_accept_o[3];
        end
        chk("t4_done", fd0, 1); chk("t4_ch3_held", acc3, 0);
        chk("t4_nbeats", log_q.size(), 3);
        chk("t4_b0", log_q[0], 32'hB000_0000); chk("t4_b1", log_q[1], 32'hB000_0001);
        chk("t4_b2", log_q[2], 32'hB000_0002);
        step(); sample();
        chk("t4_gc3", gc0, 3); chk("t4_acc3", b0.inport_accept_o, 4'b1000);
        chk("t4_data3", b0.core_data_o, 32'h3333_3333);

        // drain hold with core busy for 20 cycles
        do_reset();
        set_ch(2, 1, 32'h5555_0002, 1); b0.core_accept_i = 1'b1; b0.core_idle_i = 1'b0;
        sample();
        step(); sample();
        chk("t5_gc", gc0, 2); chk("t5_single_last", b0.core_last_o, 1);
        step(); set_ch(2, 0, 0, 0);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step();
            sample();
            bad |= fd0 | !gv0 | (gc0 != 2'd2);
        end
        chk("t5_hold", bad, 0);
        step(); b0.core_idle_i = 1'b1; sample();
        chk("t5_done", fd0, 1); chk("t5_done_gc", gc0, 2);
        step(); sample();
        chk("t5_pulse", fd0, 0); chk("t5_idle_gv", gv0, 0);

        // reset in the middle of a ch1 frame
        do_reset();
        set_ch(1, 1, 32'hE100_0001, 0); b0.core_accept_i = 1'b1;
        sample();
        step(); sample();
        chk("t6_gc", gc0, 1);
        step(); set_ch(1, 1, 32'hE100_0002, 0); rst = 1'b1; sample();
        chk("t6_beat2", b0.core_data_o, 32'hE100_0002);
        step(); rst = 1'b0; set_ch(1, 1, 32'hE100_0001, 0); set_ch(0, 1, 32'hF000_0000, 0); sample();
        chk("t6_gv", gv0, 0); chk("t6_acc", b0.inport_accept_o, 0); chk("t6_cvalid", b0.core_valid_o, 0);
        step(); sample();
        chk("t6_regv", gv0, 1); chk("t6_regc", gc0, 0); chk("t6_redata", b0.core_data_o, 32'hF000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
